// File: rtl/alu_arbiter.sv
// alu_arbiter
// Two-requester arbiter/sequencer in front of one shared combinational ALU.
// One operation is accepted at a time over a valid/ready request handshake.
// The operation is driven to the ALU from registered operands, the ALU result
// is captured, and it is returned on a per-requester valid/ready response.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   req_valid/req_ready per-requester request handshake (bit i = requester i)
//   req_op/req_a/req_b  packed payloads, requester 0 in the low slice
//   rsp_valid/rsp_ready per-requester response handshake
//   rsp_data/rsp_zero   shared result bus and zero flag, qualified by rsp_valid
//   alu_s/alu_a/alu_b   registered op select and operands to the ALU
//   alu_f               ALU result
//
// Build option
//   ALU_ARB_FIXED_PRIO_EN  defined: requester 0 always wins simultaneous
//                          requests (no round-robin pointer).
//                          undefined: round-robin between the two requesters.
//
// state | meaning
// ------+-------------------------------------------
// IDLE  | no operation held; arbitrate requests
// EXEC  | ALU inputs stable, F settling (one cycle)
// RESP  | result held until the owner takes it

module alu_arbiter #(
    parameter int W   = 4,
    parameter int OPW = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [2*OPW-1:0] req_op,
    input  logic [2*W-1:0]   req_a,
    input  logic [2*W-1:0]   req_b,
    output logic [1:0]       rsp_valid,
    input  logic [1:0]       rsp_ready,
    output logic [W-1:0]     rsp_data,
    output logic             rsp_zero,
    output logic [OPW-1:0]   alu_s,
    output logic [W-1:0]     alu_a,
    output logic [W-1:0]     alu_b,
    input  logic [W-1:0]     alu_f
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic           r_owner;
`ifndef ALU_ARB_FIXED_PRIO_EN
    logic           r_rr_ptr;
`endif
    logic [OPW-1:0] r_alu_s;
    logic [W-1:0]   r_alu_a;
    logic [W-1:0]   r_alu_b;
    logic [W-1:0]   r_rsp_data;
    logic           r_rsp_zero;

    logic           w_gnt_idx;
    logic           w_take;
    logic           w_rsp_hs;

    // Grant selection: a lone requester always wins; on a tie the pointer
    // (or requester 0 in the fixed-priority build) decides.
    always_comb begin
        w_gnt_idx = 1'b0;
        if (req_valid == 2'b10) begin
            w_gnt_idx = 1'b1;
        end else if (req_valid == 2'b11) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            w_gnt_idx = 1'b0;
`else
            w_gnt_idx = r_rr_ptr;
`endif
        end
    end

    assign w_take   = (r_state == ST_IDLE) && (req_valid != 2'b00);
    assign w_rsp_hs = (r_state == ST_RESP) && rsp_ready[r_owner];

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_take)   w_state_nxt = ST_EXEC;
            ST_EXEC:               w_state_nxt = ST_RESP;
            ST_RESP: if (w_rsp_hs) w_state_nxt = ST_IDLE;
            default:               w_state_nxt = ST_IDLE;
        endcase
    end

    // Datapath registers: operands change only on a grant, the result only
    // at the end of EXEC.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_owner    <= 1'b0;
            r_alu_s    <= {OPW{1'b1}};
            r_alu_a    <= '0;
            r_alu_b    <= '0;
            r_rsp_data <= '0;
            r_rsp_zero <= 1'b0;
        end else begin
            if (w_take) begin
                r_owner <= w_gnt_idx;
                r_alu_s <= w_gnt_idx ? req_op[2*OPW-1:OPW] : req_op[OPW-1:0];
                r_alu_a <= w_gnt_idx ? req_a[2*W-1:W]      : req_a[W-1:0];
                r_alu_b <= w_gnt_idx ? req_b[2*W-1:W]      : req_b[W-1:0];
            end
            if (r_state == ST_EXEC) begin
                r_rsp_data <= alu_f;
                r_rsp_zero <= (alu_f == '0);
            end
        end
    end

`ifndef ALU_ARB_FIXED_PRIO_EN
    // Pointer moves away from whoever just completed.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr <= 1'b0;
        end else if (w_rsp_hs) begin
            r_rr_ptr <= ~r_owner;
        end
    end
`endif

    // Outputs
    always_comb begin
        req_ready = 2'b00;
        rsp_valid = 2'b00;
        // Gate with rst so no request appears accepted on a cycle the
        // reset throws away.
        if (!rst && w_take) begin
            req_ready[w_gnt_idx] = 1'b1;
        end
        if (r_state == ST_RESP) begin
            rsp_valid[r_owner] = 1'b1;
        end
    end

    assign rsp_data = r_rsp_data;
    assign rsp_zero = r_rsp_zero;
    assign alu_s    = r_alu_s;
    assign alu_a    = r_alu_a;
    assign alu_b    = r_alu_b;

endmodule
